crc_sort_sched: RTL and testbench

//  Two-requester scheduler in front of crc_sort_core. Arbitrates CRC-3 / byte-sort commands round-robin,

---
 rtl/crc_sort_sched.sv | 162 ++++++++++++++++
 tb/tb_crc_sort_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_sort_sched.sv
// crc_sort_sched: two-requester scheduler in front of crc_sort_core.
// Grants CRC-3 / byte-sort commands round-robin, sequences the core's
// en/start/fn_sel, waits for done, and returns the captured 128-bit result
// with the requester id over a valid/ready response channel. Illegal
// function codes are answered with rsp_err=1 without touching the core.
// Build option: define CRC_SORT_FIXED_PRIO_EN for fixed priority (req0 wins
// whenever both requesters are valid); the round-robin pointer is then removed.
module crc_sort_sched #(
  parameter int         DATA_W  = 128,
  parameter logic [2:0] FN_CRC  = 3'b011,
  parameter logic [2:0] FN_SORT = 3'b100,
  parameter int         CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_fn,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_fn,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic              core_en,
  output logic              core_start,
  output logic [2:0]        core_fn_sel,
  output logic [DATA_W-1:0] core_data_in,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_done,
  output logic [CNT_W-1:0]  cmd_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic               grant_id;
  logic [2:0]         sel_fn;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_legal;
  logic               accept;
  logic               handshake;

  logic [2:0]         fn_q;
  logic [DATA_W-1:0]  data_q;
  logic               id_q;
  logic               err_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [CNT_W-1:0]   cnt_q;

`ifndef CRC_SORT_FIXED_PRIO_EN
  // 1 = requester 1 is preferred when both are valid
  logic               rr_q;
`endif

  // Pick the requester to grant and the command it presents
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
`ifdef CRC_SORT_FIXED_PRIO_EN
    grant_id = ~req0_valid;
`else
    grant_id = ~req0_valid;
    if (req0_valid && req1_valid) begin
      grant_id = rr_q;
    end
`endif
    sel_fn    = grant_id ? req1_fn   : req0_fn;
    sel_data  = grant_id ? req1_data : req0_data;
    sel_legal = (sel_fn == FN_CRC) || (sel_fn == FN_SORT);
    accept    = (state_q == S_IDLE) && (req0_valid || req1_valid);
    handshake = (state_q == S_RESP) && rsp_ready;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one command in flight, response must be taken before IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)    state_d = sel_legal ? S_ISSUE : S_RESP;
      S_ISSUE:                state_d = S_WAIT;
      S_WAIT:  if (core_done) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; ready pulses combinationally in the grant cycle
  always_comb begin
    req0_ready   = accept && !grant_id;
    req1_ready   = accept &&  grant_id;
    core_en      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    core_start   = (state_q == S_ISSUE);
    core_fn_sel  = core_en ? fn_q : 3'b000;
    core_data_in = data_q;
    rsp_valid    = (state_q == S_RESP);
    rsp_id       = id_q;
    rsp_err      = err_q;
    rsp_data     = rsp_data_q;
    cmd_cnt      = cnt_q;
  end

  // Command latch on grant, result capture on core_done while waiting
  // NOTE: the wide data registers are reset because they drive outputs that
  // must read zero out of reset, not because the logic depends on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fn_q       <= 3'b000;
      data_q     <= '0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
    end else if (accept) begin
      fn_q       <= sel_fn;
      data_q     <= sel_data;
      id_q       <= grant_id;
      err_q      <= ~sel_legal;
      rsp_data_q <= '0;
    end else if ((state_q == S_WAIT) && core_done) begin
      rsp_data_q <= core_data_out;
    end
  end

  // Completed-response counter (saturating) and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
`ifndef CRC_SORT_FIXED_PRIO_EN
      rr_q  <= 1'b0;
`endif
    end else if (handshake) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
`ifndef CRC_SORT_FIXED_PRIO_EN
      rr_q  <= ~id_q;
`endif
    end
  end

endmodule

// File: tb/tb_crc_sort_sched.sv
// tb_crc_sort_sched: self-checking bench for crc_sort_sched.
// Contains a behavioural crc_sort_core (CRC-3 poly x^3+x+1 / descending byte
// sort, done 18 cycles after start) and a transaction-level reference model.
module tb_crc_sort_sched;

  localparam int         DW      = 128;
  localparam int         CW      = 4;
  localparam logic [2:0] FN_CRC  = 3'b011;
  localparam logic [2:0] FN_SORT = 3'b100;
  localparam int         CNT_MAX = 15;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]     req0_fn, req1_fn;
  logic [DW-1:0]  req0_data, req1_data;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DW-1:0]  rsp_data;
  logic           core_en, core_start, core_done;
  logic [2:0]     core_fn_sel;
  logic [DW-1:0]  core_data_in, core_data_out;
  logic [CW-1:0]  cmd_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int prefer   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  crc_sort_sched #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fn(req0_fn), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fn(req1_fn), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .core_en(core_en), .core_start(core_start), .core_fn_sel(core_fn_sel),
    .core_data_in(core_data_in), .core_data_out(core_data_out), .core_done(core_done),
    .cmd_cnt(cmd_cnt)
  );

  function automatic logic [2:0] crc3(input logic [DW-1:0] d);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = d[i] ^ c[2];
      c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return c;
  endfunction

  // Largest byte ends up in the most significant position
  function automatic logic [DW-1:0] sort_bytes(input logic [DW-1:0] d);
    logic [7:0]    b [16];
    logic [7:0]    t;
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) b[i] = d[i*8 +: 8];
    for (int i = 0; i < 16; i++)
      for (int j = i + 1; j < 16; j++)
        if (b[j] < b[i]) begin t = b[i]; b[i] = b[j]; b[j] = t; end
    r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = b[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_core(input logic [2:0] fn, input logic [DW-1:0] d);
    if (fn == FN_CRC)  return {{(DW-3){1'b0}}, crc3(d)};
    if (fn == FN_SORT) return sort_bytes(d);
    return '0;
  endfunction

  // Behavioural core: done pulses 18 cycles after the start cycle
  int            cm_cnt;
  logic [2:0]    cm_fn;
  logic [DW-1:0] cm_data;
  logic          model_done;
  logic          inj_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_cnt        <= 0;
      cm_fn         <= 3'b000;
      cm_data       <= '0;
      model_done    <= 1'b0;
      core_data_out <= '0;
    end else begin
      model_done <= 1'b0;
      if (core_en && core_start) begin
        cm_cnt  <= 17;
        cm_fn   <= core_fn_sel;
        cm_data <= core_data_in;
      end else if (cm_cnt == 1) begin
        cm_cnt        <= 0;
        model_done    <= 1'b1;
        core_data_out <= ref_core(cm_fn, cm_data);
      end else if (cm_cnt > 1) begin
        cm_cnt <= cm_cnt - 1;
      end
    end
  end
  assign core_done = model_done | inj_done;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cnt = 0;
    prefer  = 0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [2:0] rand_fn(input bit legal_only);
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return FN_CRC;
    if (r < 8 || legal_only) return FN_SORT;
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic refill(input int r, input bit legal_only);
    if (r == 0) begin
      req0_fn = rand_fn(legal_only); req0_data = rand_data(); req0_valid = 1'b1;
    end else begin
      req1_fn = rand_fn(legal_only); req1_data = rand_data(); req1_valid = 1'b1;
    end
  endtask

  // One full transaction from grant to response handshake, checked against the model
  task automatic run_txn(input bit stall);
    bit            found, legal, en_seen, stable_ok, v0, v1, got;
    int            exp_id, lat;
    logic [2:0]    afn;
    logic [DW-1:0] adata, exp_data, held;
    found = 0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin found = 1; break; end
      @(posedge clk); #1;
    end
    if (!found) begin check("grant_timeout", 1'b0, 1'b1); return; end
    v0 = req0_valid; v1 = req1_valid;
`ifdef CRC_SORT_FIXED_PRIO_EN
    exp_id = v0 ? 0 : 1;
`else
    exp_id = (v0 && v1) ? prefer : (v0 ? 0 : 1);
`endif
    prefer = 1 - exp_id;
    check("both_ready", req0_ready && req1_ready, 1'b0);
    check("grant_id", req1_ready, exp_id);
    got      = req1_ready;
    afn      = exp_id ? req1_fn : req0_fn;
    adata    = exp_id ? req1_data : req0_data;
    legal    = (afn == FN_CRC) || (afn == FN_SORT);
    exp_data = legal ? ref_core(afn, adata) : '0;
    @(posedge clk); #1;
    if (got) req1_valid = 1'b0; else req0_valid = 1'b0;
    lat = 1; en_seen = 0; found = 0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (core_en) en_seen = 1;
      if (lat == 1 && legal) begin
        check("start_c1", core_start, 1'b1);
        check("fn_sel_c1", core_fn_sel, afn);
        check("data_in_c1", core_data_in, adata);
      end
      if (rsp_valid) begin found = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    if (!found) begin check("rsp_timeout", 1'b0, 1'b1); return; end
    check("latency", lat, legal ? 20 : 1);
    if (!legal) check("core_unused", en_seen, 1'b0);
    check("rsp_id", rsp_id, exp_id);
    check("rsp_err", rsp_err, !legal);
    check("rsp_data", rsp_data, exp_data);
    if (stall) begin
      stable_ok = 1; held = rsp_data;
      for (int s = 0; s < 10; s++) begin
        inj_done = (s == 3);
        @(posedge clk); #1;
        inj_done = 1'b0;
        @(negedge clk);
        if (!rsp_valid || rsp_data !== held || req0_ready || req1_ready || core_en) stable_ok = 0;
      end
      check("stall_stable", stable_ok, 1'b1);
      check("stall_cnt", cmd_cnt, exp_cnt);
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1;
    check("cmd_cnt", cmd_cnt, exp_cnt);
    check("rsp_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0; rsp_ready = 1'b1; inj_done = 1'b0;
    req0_valid = 1'b0; req0_fn = 3'b000; req0_data = '0;
    req1_valid = 1'b0; req1_fn = 3'b000; req1_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_core", {core_en, core_start, core_fn_sel}, '0);
    check("rst_rsp", {rsp_id, rsp_err, rsp_data}, '0);
    check("rst_cnt", cmd_cnt, '0);
    check("rst_ready", {req0_ready, req1_ready}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed: CRC of zero from req0, SORT from req1, illegal fn from req0
    req0_fn = FN_CRC; req0_data = '0; req0_valid = 1'b1;
    run_txn(0);
    req1_fn = FN_SORT; req1_data = 128'h000102030405060708090A0B0C0D0E0F; req1_valid = 1'b1;
    run_txn(0);
    req0_fn = 3'b111; req0_data = rand_data(); req0_valid = 1'b1;
    run_txn(0);

    // Both requesters valid continuously for four commands
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!req0_valid) refill(0, 1);
      if (!req1_valid) refill(1, 1);
      run_txn(0);
    end
    check("cnt_after4", cmd_cnt, 4);

    // Response back-pressure with the other requester waiting, then drain
    if (!req0_valid) refill(0, 1);
    if (!req1_valid) refill(1, 1);
    rsp_ready = 1'b0;
    run_txn(1);
    run_txn(0);

    // Spurious core_done while idle is ignored
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    @(negedge clk);
    check("idle_done_ignored", {rsp_valid, core_en}, '0);
    @(posedge clk); #1;

    // Reset asserted while the core is busy
    req0_fn = FN_SORT; req0_data = rand_data(); req0_valid = 1'b1;
    found = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (req0_ready) begin found = 1; break; end
      @(posedge clk); #1;
    end
    check("rst_mid_grant", found, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_busy", core_en, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_core", {core_en, core_start, core_fn_sel, core_data_in}, '0);
    check("rst_mid_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, '0);
    check("rst_mid_cnt", {req0_ready, req1_ready, cmd_cnt}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; exp_cnt = 0; prefer = 0;
    req0_fn = FN_CRC; req0_data = rand_data(); req0_valid = 1'b1;
    run_txn(0);

    // Randomized traffic; also drives cmd_cnt into saturation
    for (int i = 0; i < 16; i++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) refill(0, 0);
      if (!req1_valid && $urandom_range(0, 1) == 1) refill(1, 0);
      if (!req0_valid && !req1_valid) refill(int'($urandom_range(0, 1)), 0);
      run_txn(0);
    end
    for (int i = 0; i < 2; i++) if (req0_valid || req1_valid) run_txn(0);
    check("cnt_saturated", cmd_cnt, CNT_MAX);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
